mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width.
REQ-002 SHALL have parameter REGION_W, default 4, width of region field A[AWIDTH-1 -: REGION_W].
REQ-003 SHALL have parameters IO_BIT=3, DMEM_BIT=0, IMEM_BIT=1, region-field bit positions selecting IO, DMEM, IMEM.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports listed below, clock and reset first.
REQ-005 Clock  in  1  rising-edge clock.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 Req_valid in 1, Req_ready out 1: request handshake; transfer when both high on a rising edge.
REQ-008 Opcode in 7, Funct3 in 3, A in AWIDTH, Wdata in 32: request fields; only OPC_LOAD and OPC_STORE are legal.
REQ-009 Mem_addr out AWIDTH (registered A, bits[1:0]=0); Mem_wdata out 32; Dmem_enable out 4; Imem_enable out 4; Dmem_rdata in 32, synchronous read, valid the cycle after address issue.
REQ-010 Io_trans out 4 (store byte enables), Io_recv out 1, Io_rdata in 32, Io_ready in 1: IO handshake.
REQ-011 Resp_valid out 1, Resp_data out 32, Err out 1: one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, IO_WAIT, RESP; Req_ready=1 only in IDLE.
REQ-013 Accept at edge T: legal request -> ISSUE (cycle T+1); illegal request -> RESP directly (Resp_valid and Err=1 at T+1, Resp_data=0, no enables).
REQ-014 Illegal: opcode not LOAD/STORE, Funct3 not legal for that opcode, region with none of IO/DMEM bits set, load with only IMEM bit set.
REQ-015 Decode priority: IO bit set -> IO; else DMEM bit -> DMEM; store with IMEM bit also asserts identical Imem_enable.
REQ-016 Byte enables: SB 0001<<A[1:0]; SH 0011<<{A[1],0}; SW 1111; all enables 0 for loads.
REQ-017 Mem_wdata: SB byte replicated on 4 lanes; SH halfword replicated on 2 lanes; SW Wdata.
REQ-018 Memory access: enables and Mem_addr driven in ISSUE for exactly one cycle; ISSUE -> RESP; Resp_valid at T+2.
REQ-019 IO access: Io_trans (store) or Io_recv (load) asserted from ISSUE, held through IO_WAIT, until the cycle Io_ready=1 inclusive; Io_rdata captured that cycle; RESP next cycle.
REQ-020 Load data: LB/LBU select byte A[1:0], LH/LHU halfword A[1], sign- or zero-extended; LW whole word; source Dmem_rdata in RESP (combinational) or captured Io_rdata.
REQ-021 Store responses: Resp_data=0, Err=0.
REQ-022 RESP lasts one cycle then IDLE; peak throughput one request per 3 cycles.
REQ-023 Req_valid during non-IDLE states SHALL be ignored; request fields are sampled only at acceptance.

Reset
REQ-024 Reset in any state -> IDLE on that edge; all enables, Io_trans, Io_recv, Resp_valid, Err = 0, Resp_data = 0, Mem_addr = 0.
REQ-025 A request in flight at reset SHALL be dropped with no Resp_valid.

Configuration
REQ-026 Macro MEMCTL_MISALIGN_TRAP_EN defined: LH/LHU/SH with A[0]=1, or LW/SW with A[1:0]!=0, SHALL be illegal (REQ-013).
REQ-027 Macro undefined: misaligned low bits ignored (halfword uses A[1], word forced aligned), no Err from alignment.

Verification
REQ-028 SB A=0x1000_0003, Wdata=0x0000_00AB -> T+1 Dmem_enable=1000, Imem_enable=0000, Mem_wdata=0xABAB_ABAB; T+2 Resp_valid=1, Err=0.
REQ-029 SW A=0x3000_0000, Wdata=0x1234_5678 -> T+1 Dmem_enable=1111, Imem_enable=1111, Mem_wdata=0x1234_5678.
REQ-030 LB A=0x1000_0002, Dmem_rdata=0x0080_0000 at T+2 -> Resp_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-031 LW A=0x8000_0004, Io_ready low 3 cycles then high with Io_rdata=0xDEAD_BEEF -> Io_recv high T+1..T+4, Resp_valid at T+5, Resp_data=0xDEAD_BEEF.
REQ-032 SH A=0x1000_0001: macro defined -> T+1 Resp_valid=1, Err=1, enables 0; undefined -> T+1 Dmem_enable=0011.
REQ-033 Reset high while in IO_WAIT -> next cycle Io_recv=0, Req_ready=1, no Resp_valid; A=0x0000_0000 load -> Err=1 at T+1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences single load/store requests onto a DMEM/IMEM port
// or a handshaked IO port and returns one completion pulse per request.
// Optional feature: define MEMCTL_MISALIGN_TRAP_EN to make misaligned halfword
// and word accesses illegal (Err response); otherwise the low address bits that
// do not fit the access size are ignored.
module mem_access_unit #(
    parameter int AWIDTH   = 32,
    parameter int REGION_W = 4,
    parameter int IO_BIT   = 3,
    parameter int DMEM_BIT = 0,
    parameter int IMEM_BIT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic [6:0]        Opcode,
    input  logic [2:0]        Funct3,
    input  logic [AWIDTH-1:0] A,
    input  logic [31:0]       Wdata,
    output logic [AWIDTH-1:0] Mem_addr,
    output logic [31:0]       Mem_wdata,
    output logic [3:0]        Dmem_enable,
    output logic [3:0]        Imem_enable,
    input  logic [31:0]       Dmem_rdata,
    output logic [3:0]        Io_trans,
    output logic              Io_recv,
    input  logic [31:0]       Io_rdata,
    input  logic              Io_ready,
    output logic              Resp_valid,
    output logic [31:0]       Resp_data,
    output logic              Err
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    // Bit offset of the region field inside the address.
    localparam int RBASE = AWIDTH - REGION_W;

    typedef enum logic [1:0] {IDLE, ISSUE, IO_WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              store_q, store_d;
    logic              io_q, io_d;
    logic              imem_q, imem_d;
    logic              err_q, err_d;
    logic [31:0]       io_data_q, io_data_d;

    logic req_load, req_store, f3_legal, region_ok, misaligned, req_legal;

    // Classify the incoming request as legal or illegal.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_load   = (Opcode == OPC_LOAD);
        req_store  = (Opcode == OPC_STORE);
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        if (req_load) begin
            f3_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                       (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end else if (req_store) begin
            f3_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end
        // An IMEM-only region is not a valid target, even for stores.
        region_ok = A[RBASE+IO_BIT] | A[RBASE+DMEM_BIT];
`ifdef MEMCTL_MISALIGN_TRAP_EN
        if (Funct3[1:0] == 2'b01) begin
            misaligned = A[0];
        end else if (Funct3[1:0] == 2'b10) begin
            misaligned = |A[1:0];
        end
`endif
        req_legal = f3_legal & region_ok & ~misaligned;
    end

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    // Byte-lane steering for stores and extraction/extension for loads.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << {addr_q[1], 1'b0};
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase

        load_src = io_q ? io_data_q : Dmem_rdata;
        case (addr_q[1:0])
            2'b00:   ld_byte = load_src[7:0];
            2'b01:   ld_byte = load_src[15:8];
            2'b10:   ld_byte = load_src[23:16];
            default: ld_byte = load_src[31:24];
        endcase
        ld_half = addr_q[1] ? load_src[31:16] : load_src[15:0];

        // funct3[2] set selects the unsigned (zero-extending) variants.
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: load_data = load_src;
        endcase
    end

    // Next-state, request capture and output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        store_d     = store_q;
        io_d        = io_q;
        imem_d      = imem_q;
        err_d       = err_q;
        io_data_d   = io_data_q;
        Req_ready   = 1'b0;
        Mem_addr    = '0;
        Mem_wdata   = '0;
        Dmem_enable = '0;
        Imem_enable = '0;
        Io_trans    = '0;
        Io_recv     = 1'b0;
        Resp_valid  = 1'b0;
        Resp_data   = '0;
        Err         = 1'b0;

        case (state_q)
            IDLE: begin
                Req_ready = 1'b1;
                if (Req_valid) begin
                    addr_d   = A;
                    wdata_d  = Wdata;
                    funct3_d = Funct3;
                    store_d  = req_store;
                    io_d     = A[RBASE+IO_BIT];
                    // IO takes priority, so the IMEM mirror only applies to memory stores.
                    imem_d   = req_store & A[RBASE+IMEM_BIT] & ~A[RBASE+IO_BIT];
                    err_d    = ~req_legal;
                    state_d  = req_legal ? ISSUE : RESP;
                end
            end
            ISSUE, IO_WAIT: begin
                Mem_addr  = {addr_q[AWIDTH-1:2], 2'b00};
                Mem_wdata = store_q ? lane_wdata : '0;
                if (io_q) begin
                    Io_trans = store_q ? lane_be : 4'b0000;
                    Io_recv  = ~store_q;
                    if (Io_ready) begin
                        io_data_d = Io_rdata;
                        state_d   = RESP;
                    end else begin
                        state_d   = IO_WAIT;
                    end
                end else begin
                    // Memory accesses only ever pass through ISSUE, so enables last one cycle.
                    Dmem_enable = store_q ? lane_be : 4'b0000;
                    Imem_enable = imem_q ? lane_be : 4'b0000;
                    state_d     = RESP;
                end
            end
            RESP: begin
                Resp_valid = 1'b1;
                Err        = err_q;
                Resp_data  = (err_q | store_q) ? '0 : load_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; an in-flight request is simply dropped.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request payload registers.
    always_ff @(posedge Clock) begin
        // NOTE: payload is not reset; every output using it is gated by a non-IDLE state.
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        funct3_q  <= funct3_d;
        store_q   <= store_d;
        io_q      <= io_d;
        imem_q    <= imem_d;
        err_q     <= err_d;
        io_data_q <= io_data_d;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench for
// mem_access_unit, compared against a behavioural model of the access rules.
// Honours MEMCTL_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_access_unit;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req_valid;
    logic        Req_ready;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic [31:0] A;
    logic [31:0] Wdata;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_wdata;
    logic [3:0]  Dmem_enable;
    logic [3:0]  Imem_enable;
    logic [31:0] Dmem_rdata;
    logic [3:0]  Io_trans;
    logic        Io_recv;
    logic [31:0] Io_rdata;
    logic        Io_ready;
    logic        Resp_valid;
    logic [31:0] Resp_data;
    logic        Err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Req_valid   (Req_valid),
        .Req_ready   (Req_ready),
        .Opcode      (Opcode),
        .Funct3      (Funct3),
        .A           (A),
        .Wdata       (Wdata),
        .Mem_addr    (Mem_addr),
        .Mem_wdata   (Mem_wdata),
        .Dmem_enable (Dmem_enable),
        .Imem_enable (Imem_enable),
        .Dmem_rdata  (Dmem_rdata),
        .Io_trans    (Io_trans),
        .Io_recv     (Io_recv),
        .Io_rdata    (Io_rdata),
        .Io_ready    (Io_ready),
        .Resp_valid  (Resp_valid),
        .Resp_data   (Resp_data),
        .Err         (Err)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (opc == OPC_LOAD)       ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else if (opc == OPC_STORE) ok = (f3 <= 2);
        else                       ok = 1'b0;
        if (!a[31] && !a[28]) ok = 1'b0;   // neither IO nor DMEM region bit
`ifdef MEMCTL_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'd1 && a[0])         ok = 1'b0;
        if (f3[1:0] == 2'd2 && a[1:0] != 0)  ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        case (f3[1:0])
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << (2 * (off / 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] src);
        int          off;
        logic [31:0] v;
        off = int'(a[1:0]);
        case (f3[1:0])
            2'd0: begin
                v = (src >> (8 * off)) & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (src >> (16 * (off / 2))) & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = src;
        endcase
        return v;
    endfunction

    // Garbage on the request bus while busy must be ignored.
    task automatic scramble();
        Req_valid = 1'($urandom_range(0, 1));
        Opcode    = 7'($urandom);
        Funct3    = 3'($urandom);
        A         = $urandom;
        Wdata     = $urandom;
    endtask

    // One complete transaction, checked cycle by cycle against the model.
    task automatic do_req(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int io_wait, input logic [31:0] rdata);
        bit          legal;
        bit          st;
        bit          io;
        logic [3:0]  be;
        legal = ref_legal(opc, f3, a);
        st    = (opc == OPC_STORE);
        io    = a[31];
        be    = ref_be(f3, a);

        Opcode = opc; Funct3 = f3; A = a; Wdata = wd; Req_valid = 1'b1;
        #1 check("req_ready_idle", 32'(Req_ready), 32'd1);
        @(posedge Clock); #1;
        scramble();

        if (!legal) begin
            check("ill_resp_valid", 32'(Resp_valid), 32'd1);
            check("ill_err", 32'(Err), 32'd1);
            check("ill_resp_data", Resp_data, 32'd0);
            check("ill_enables", 32'({Dmem_enable, Imem_enable, Io_trans, Io_recv}), 32'd0);
        end else if (!io) begin
            check("mem_dmem_en", 32'(Dmem_enable), st ? 32'(be) : 32'd0);
            check("mem_imem_en", 32'(Imem_enable), (st && a[29]) ? 32'(be) : 32'd0);
            check("mem_addr", Mem_addr, a & ~32'd3);
            if (st) check("mem_wdata", Mem_wdata, ref_wdata(f3, wd));
            check("issue_busy", 32'(Req_ready), 32'd0);
            check("issue_no_resp", 32'(Resp_valid), 32'd0);
            @(posedge Clock); #1;
            Dmem_rdata = rdata;
            #1;
            check("mem_resp_valid", 32'(Resp_valid), 32'd1);
            check("mem_err", 32'(Err), 32'd0);
            check("mem_resp_data", Resp_data, st ? 32'd0 : ref_load(f3, a, rdata));
            check("mem_en_dropped", 32'({Dmem_enable, Imem_enable}), 32'd0);
        end else begin
            for (int k = 0; k <= io_wait; k++) begin
                check("io_trans", 32'(Io_trans), st ? 32'(be) : 32'd0);
                check("io_recv", 32'(Io_recv), st ? 32'd0 : 32'd1);
                check("io_no_resp", 32'(Resp_valid), 32'd0);
                check("io_no_dmem", 32'({Dmem_enable, Imem_enable}), 32'd0);
                if (k == io_wait) begin
                    Io_ready = 1'b1; Io_rdata = rdata;
                end else begin
                    Io_ready = 1'b0; Io_rdata = $urandom;
                end
                @(posedge Clock); #1;
            end
            Io_ready = 1'b0;
            Io_rdata = $urandom;
            #1;
            check("io_resp_valid", 32'(Resp_valid), 32'd1);
            check("io_err", 32'(Err), 32'd0);
            check("io_resp_data", Resp_data, st ? 32'd0 : ref_load(f3, a, rdata));
            check("io_released", 32'({Io_trans, Io_recv}), 32'd0);
        end

        @(posedge Clock); #1;
        Req_valid = 1'b0;
        check("back_idle", 32'(Req_ready), 32'd1);
        check("idle_no_resp", 32'(Resp_valid), 32'd0);
    endtask

    logic [3:0] regions [8];

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;

        regions[0] = 4'h1; regions[1] = 4'h3; regions[2] = 4'h8; regions[3] = 4'h9;
        regions[4] = 4'hC; regions[5] = 4'h0; regions[6] = 4'h2; regions[7] = 4'h5;

        Reset = 1'b1; Req_valid = 1'b0; Opcode = '0; Funct3 = '0; A = '0; Wdata = '0;
        Dmem_rdata = '0; Io_rdata = '0; Io_ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_ready", 32'(Req_ready), 32'd1);
        check("rst_resp", 32'({Resp_valid, Err}), 32'd0);
        check("rst_resp_data", Resp_data, 32'd0);
        check("rst_mem_addr", Mem_addr, 32'd0);
        check("rst_enables", 32'({Dmem_enable, Imem_enable, Io_trans, Io_recv}), 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // Directed scenarios
        do_req(OPC_STORE, 3'b000, 32'h1000_0003, 32'h0000_00AB, 0, 32'h0);          // SB
        do_req(OPC_STORE, 3'b010, 32'h3000_0000, 32'h1234_5678, 0, 32'h0);          // SW to DMEM+IMEM
        do_req(OPC_LOAD,  3'b000, 32'h1000_0002, 32'h0, 0, 32'h0080_0000);          // LB
        do_req(OPC_LOAD,  3'b100, 32'h1000_0002, 32'h0, 0, 32'h0080_0000);          // LBU
        do_req(OPC_LOAD,  3'b010, 32'h8000_0004, 32'h0, 3, 32'hDEAD_BEEF);          // LW from IO
        do_req(OPC_STORE, 3'b001, 32'h1000_0001, 32'h0000_CAFE, 0, 32'h0);          // SH misaligned
        do_req(OPC_LOAD,  3'b010, 32'h1000_0003, 32'h0, 0, 32'h8765_4321);          // LW misaligned
        do_req(OPC_STORE, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 2, 32'h0);          // SH to IO
        do_req(OPC_LOAD,  3'b101, 32'h1000_0002, 32'h0, 0, 32'h8001_0002);          // LHU upper

        // Directed value spot checks independent of the model
        Opcode = OPC_STORE; Funct3 = 3'b000; A = 32'h1000_0003; Wdata = 32'h0000_00AB; Req_valid = 1'b1;
        @(posedge Clock); #1;
        Req_valid = 1'b0;
        check("sb_dir_dmem_en", 32'(Dmem_enable), 32'h8);
        check("sb_dir_wdata", Mem_wdata, 32'hABAB_ABAB);
        @(posedge Clock); #1;
        check("sb_dir_resp", 32'({Resp_valid, Err}), 32'h2);
        @(posedge Clock); #1;

        // Reset while waiting on IO drops the request
        Opcode = OPC_LOAD; Funct3 = 3'b010; A = 32'h8000_0004; Req_valid = 1'b1; Io_ready = 1'b0;
        @(posedge Clock); #1;
        Req_valid = 1'b0;
        check("rst_io_issue", 32'(Io_recv), 32'd1);
        @(posedge Clock); #1;
        check("rst_io_wait", 32'(Io_recv), 32'd1);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("rst_io_recv", 32'(Io_recv), 32'd0);
        check("rst_io_ready", 32'(Req_ready), 32'd1);
        check("rst_io_noresp", 32'(Resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            Io_ready = 1'b1;
            @(posedge Clock); #1;
            check("rst_dropped", 32'(Resp_valid), 32'd0);
        end
        Io_ready = 1'b0;
        do_req(OPC_LOAD, 3'b010, 32'h0000_0000, 32'h0, 0, 32'h0);                   // no region -> Err

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 7));
            if (r <= 2 || r == 7) opc = OPC_LOAD;
            else if (r <= 5)      opc = OPC_STORE;
            else                  opc = 7'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                f3 = 3'($urandom_range(0, 2));
                if (opc == OPC_LOAD && $urandom_range(0, 1) == 1 && f3 != 3'd2) f3 = f3 | 3'b100;
            end
            a = $urandom;
            a[31:28] = regions[$urandom_range(0, 7)];
            do_req(opc, f3, a, $urandom, int'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
